// File: rtl/pll_domain_sequencer_if.sv
// Bundle of PLL supervision and per-domain reset/clock-enable signals.
// Optional macro LOCK_LOSS_COUNT_EN adds the lock_loss_count status field.
interface pll_domain_sequencer_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 8
);
  logic                          pll_locked;
  logic                          pll_rst;
  logic [CHANNELS*DIV_WIDTH-1:0] div;
  logic [CHANNELS-1:0]           chan_reset;
  logic [CHANNELS-1:0]           ce;
  logic                          ready;
  logic [2:0]                    state;
  logic [7:0]                    retry_count;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0]                    lock_loss_count;

  modport master (
    input  pll_locked, div,
    output pll_rst, chan_reset, ce, ready, state, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked, div,
    input  pll_rst, chan_reset, ce, ready, state, retry_count, lock_loss_count
  );
`else
  modport master (
    input  pll_locked, div,
    output pll_rst, chan_reset, ce, ready, state, retry_count
  );

  modport slave (
    output pll_locked, div,
    input  pll_rst, chan_reset, ce, ready, state, retry_count
  );
`endif
endinterface

// File: rtl/pll_domain_sequencer.sv
// PLL lock supervisor: retries the PLL on lock timeout, releases per-domain resets in
// staged order once lock is stable, and generates a divided clock-enable per channel.
// Optional macro LOCK_LOSS_COUNT_EN adds a saturating count of lock-loss events.
module pll_domain_sequencer #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned PLL_RST_CYCLES = 16
) (
  input logic                    clock,
  input logic                    reset,
  pll_domain_sequencer_if.master bus
);

  localparam int unsigned SeqLen = STAGE_GAP * CHANNELS;
  localparam int unsigned Max1   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int unsigned Max2   = (SeqLen > PLL_RST_CYCLES) ? SeqLen : PLL_RST_CYCLES;
  localparam int unsigned MaxCnt = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] SeqLast     = CntW'(SeqLen - 1);

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StStable   = 3'd1,
    StSeq      = 3'd2,
    StRun      = 3'd3,
    StPllRst   = 3'd4
  } state_e;

  state_e                              state_q, state_d;
  logic                                sync1_q, locked_s_q;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [7:0]                          retry_q, retry_d;
  logic [CHANNELS-1:0]                 chan_reset_q, chan_reset_d;
  logic                                ready_q, ready_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [CHANNELS-1:0]                 ce_q, ce_d;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Supervisor and sequencer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StWaitLock;
      cnt_q        <= '0;
      retry_q      <= '0;
      chan_reset_q <= '1;
      ready_q      <= 1'b0;
      div_cnt_q    <= '0;
      ce_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      chan_reset_q <= chan_reset_d;
      ready_q      <= ready_d;
      div_cnt_q    <= div_cnt_d;
      ce_q         <= ce_d;
    end
  end

  // Next-state logic; one shared counter serves as timer, stability and stage counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    retry_d      = retry_q;
    chan_reset_d = chan_reset_q;
    ready_d      = ready_q;
    unique case (state_q)
      StWaitLock: begin
        if (locked_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          cnt_d   = '0;
          if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
        end
      end
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StStable: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StSeq;
          cnt_d   = '0;
        end
      end
      StSeq, StRun: begin
        if (!locked_s_q) begin
          // All domains drop back into reset together.
          state_d      = StWaitLock;
          cnt_d        = '0;
          chan_reset_d = '1;
          ready_d      = 1'b0;
        end else if (state_q == StRun) begin
          cnt_d = '0;
        end else begin
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (cnt_q == CntW'(STAGE_GAP * (k + 1) - 1)) chan_reset_d[k] = 1'b0;
          end
          if (cnt_q == SeqLast) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-channel divider; ce is suppressed on the edge a channel re-enters reset.
  always_comb begin
    div_cnt_d = '0;
    ce_d      = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!chan_reset_q[k]) begin
        if (div_cnt_q[k] == bus.div[k*DIV_WIDTH +: DIV_WIDTH]) begin
          div_cnt_d[k] = '0;
          ce_d[k]      = ~chan_reset_d[k];
        end else begin
          div_cnt_d[k] = div_cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_q;
  logic       loss_event;

  assign loss_event = !locked_s_q &&
                      (state_q == StStable || state_q == StSeq || state_q == StRun);

  // Saturating count of lock losses after lock was first seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_q <= '0;
    end else if (loss_event && loss_q != 8'hff) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_count = loss_q;
`endif

  assign bus.pll_rst     = (state_q == StPllRst);
  assign bus.chan_reset  = chan_reset_q;
  assign bus.ce          = ce_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_domain_sequencer.sv
// Self-checking bench for pll_domain_sequencer (CHANNELS=3, small timing parameters).
module tb_pll_domain_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pll_domain_sequencer_if #(.CHANNELS(3), .DIV_WIDTH(8)) bus ();

  pll_domain_sequencer #(
    .CHANNELS      (3),
    .DIV_WIDTH     (8),
    .LOCK_STABLE   (8),
    .STAGE_GAP     (4),
    .LOCK_TIMEOUT  (64),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         at;
    logic       locked;
    logic [2:0] st;
    logic [2:0] cr;
    logic       rdy;
    logic       prst;
    logic [7:0] rc;
    logic [2:0] ce;
  } vec_t;

  vec_t sb_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int at, input logic [7:0] act,
                       input logic [7:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, at, act, want);
    end
  endtask

  // Scoreboard: compare queued expectations against DUT outputs mid-cycle.
  always @(negedge clock) begin : monitor
    vec_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      if (e.at < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard entry for cycle %0d missed at %0d", e.at, cyc);
      end else begin
        check("state",       e.at, {5'd0, bus.state},      {5'd0, e.st});
        check("chan_reset",  e.at, {5'd0, bus.chan_reset}, {5'd0, e.cr});
        check("ready",       e.at, {7'd0, bus.ready},      {7'd0, e.rdy});
        check("pll_rst",     e.at, {7'd0, bus.pll_rst},    {7'd0, e.prst});
        check("retry_count", e.at, bus.retry_count,        e.rc);
        check("ce",          e.at, {5'd0, bus.ce},         {5'd0, e.ce});
      end
    end
  end

  function automatic vec_t mk(int at, logic l, logic [2:0] st, logic [2:0] cr, logic rdy,
                              logic prst, logic [7:0] rc, logic [2:0] ce);
    vec_t v;
    v.at = at; v.locked = l; v.st = st; v.cr = cr;
    v.rdy = rdy; v.prst = prst; v.rc = rc; v.ce = ce;
    return v;
  endfunction

  // Expected timeline for lock at p, divisors {0,3,1}, lock input dropped at p+30.
  function automatic vec_t model(int p, int off);
    vec_t v;
    int rel[3];
    int dv[3];
    rel = '{15, 19, 23};
    dv  = '{1, 3, 0};
    v.at = p + off; v.locked = 1'b1; v.prst = 1'b0; v.rc = 8'd0;
    if (off < 3)       v.st = 3'd0;
    else if (off < 11) v.st = 3'd1;
    else if (off < 23) v.st = 3'd2;
    else if (off < 33) v.st = 3'd3;
    else               v.st = 3'd0;
    v.rdy = (off >= 23 && off < 33);
    for (int k = 0; k < 3; k++) begin
      v.cr[k] = !(off >= rel[k] && off < 33);
      v.ce[k] = (off > rel[k] && off < 33 && ((off - rel[k]) % (dv[k] + 1)) == 0);
    end
    return v;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations never reached", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset          = 1'b1;
    bus.pll_locked = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t clean[11];
    vec_t tmo[12];
    vec_t v;
    int   p;

    bus.pll_locked = 1'b0;
    bus.div        = '1;

    // Clean lock: staged release at 12/16/20 cycles after STABLE entry.
    clean[0]  = mk( 0, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[1]  = mk( 3, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[2]  = mk(10, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[3]  = mk(11, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[4]  = mk(14, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[5]  = mk(15, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[6]  = mk(18, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[7]  = mk(19, 1'b1, 3'd2, 3'b100, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[8]  = mk(22, 1'b1, 3'd2, 3'b100, 1'b0, 1'b0, 8'd0, 3'b000);
    clean[9]  = mk(23, 1'b1, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0, 3'b000);
    clean[10] = mk(33, 1'b1, 3'd3, 3'b000, 1'b1, 1'b0, 8'd0, 3'b000);
    do_reset();
    p = cyc;
    for (int i = 0; i < 11; i++) begin
      v    = clean[i];
      v.at = p + v.at;
      sb_q.push_back(v);
      goto(v.at);
      bus.pll_locked = v.locked;
    end
    drain();

    // Timeout retry: 64-cycle wait, 4-cycle pll_rst, repeating every 68 cycles.
    tmo[0]  = mk(  0, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    tmo[1]  = mk( 63, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000);
    tmo[2]  = mk( 64, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd1, 3'b000);
    tmo[3]  = mk( 67, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd1, 3'b000);
    tmo[4]  = mk( 68, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd1, 3'b000);
    tmo[5]  = mk(131, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd1, 3'b000);
    tmo[6]  = mk(132, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd2, 3'b000);
    tmo[7]  = mk(135, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd2, 3'b000);
    tmo[8]  = mk(136, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd2, 3'b000);
    tmo[9]  = mk(199, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd2, 3'b000);
    tmo[10] = mk(200, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd3, 3'b000);
    tmo[11] = mk(201, 1'b0, 3'd4, 3'b111, 1'b0, 1'b1, 8'd3, 3'b000);
    do_reset();
    p = cyc;
    for (int i = 0; i < 12; i++) begin
      v    = tmo[i];
      v.at = p + v.at;
      sb_q.push_back(v);
      goto(v.at);
      bus.pll_locked = v.locked;
    end
    // Reset during the second pll_rst cycle cuts the pulse and clears retry_count.
    sb_q.push_back(mk(p + 202, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 203, 1'b0, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    reset = 1'b1;
    goto(p + 202);
    reset = 1'b0;
    drain();

    // Stable glitch: one-cycle lock drop at stable count 5 restarts the count.
    bus.div = '1;
    do_reset();
    p = cyc;
    sb_q.push_back(mk(p +  8, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p +  9, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 10, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 17, 1'b1, 3'd1, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 18, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 21, 1'b1, 3'd2, 3'b111, 1'b0, 1'b0, 8'd0, 3'b000));
    sb_q.push_back(mk(p + 22, 1'b1, 3'd2, 3'b110, 1'b0, 1'b0, 8'd0, 3'b000));
    bus.pll_locked = 1'b1;
    goto(p + 6);
    bus.pll_locked = 1'b0;
    goto(p + 7);
    bus.pll_locked = 1'b1;
    drain();

    // Dividers {0,3,1}, then lock loss in RUN: everything back in reset together.
    bus.div = {8'd0, 8'd3, 8'd1};
    do_reset();
    p = cyc;
    for (int off = 0; off <= 40; off++) sb_q.push_back(model(p, off));
    bus.pll_locked = 1'b1;
    goto(p + 30);
    bus.pll_locked = 1'b0;
    drain();
`ifdef LOCK_LOSS_COUNT_EN
    check("lock_loss_count", cyc, bus.lock_loss_count, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
